// File: rtl/axis_drop_fifo_pkg.sv
// Shared types and helpers for the ingress drop FIFO.
//   state_t      : packet-level write FSM state
//   entry_width  : width of one stored beat {tdata, tdest, tkeep, tlast}
package axis_drop_fifo_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccept,
        StDrop
    } state_t;

    function automatic int unsigned entry_width(int unsigned bus_width, int unsigned dest_width);
        return bus_width + dest_width + bus_width / 8 + 1;
    endfunction

endpackage

// File: rtl/axis_ingress_drop_fifo_if.sv
// AXI-Stream bundle used on both sides of the ingress drop FIFO.
//   tdata/tdest/tkeep/tlast/tvalid : driven by the master
//   tready                         : driven by the slave
interface axis_ingress_drop_fifo_if #(
    parameter int unsigned BUS_WIDTH  = 64,
    parameter int unsigned DEST_WIDTH = 4
);
    logic [BUS_WIDTH-1:0]   tdata;
    logic [DEST_WIDTH-1:0]  tdest;
    logic [BUS_WIDTH/8-1:0] tkeep;
    logic                   tlast;
    logic                   tvalid;
    logic                   tready;

    modport master (
        output tdata, tdest, tkeep, tlast, tvalid,
        input  tready
    );

    modport slave (
        input  tdata, tdest, tkeep, tlast, tvalid,
        output tready
    );
endinterface

// File: rtl/axis_drop_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset on storage.
//   clk      : clock
//   wr_en    : write strobe for wr_addr/wr_data
//   rd_addr  : read address, data appears on rd_data after the next clock edge
//   rd_data  : registered read data (read-before-write on address collision)
module axis_drop_fifo_ram #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);
    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/axis_ingress_drop_fifo.sv
// Store-and-forward ingress buffer that never backpressures its source. Whole packets that
// do not fit are discarded so the tenant never sees a truncated packet.
//   aclk, areset     : clock, asynchronous active-high reset
//   axis_s           : ingress stream (tready is 1 whenever out of reset)
//   axis_m           : buffered stream to the tenant, one output register (FWFT)
//   packet_committed : 1-cycle pulse after a packet's tlast is stored
//   packet_dropped   : 1-cycle pulse after a discarded packet's tlast
//   occupancy        : committed beats still in memory (not yet in the output register)
module axis_ingress_drop_fifo
    import axis_drop_fifo_pkg::*;
#(
    parameter int unsigned AXIS_BUS_WIDTH  = 64,
    parameter int unsigned AXIS_DEST_WIDTH = 4,
    parameter int unsigned FIFO_DEPTH_LOG2 = 9
) (
    input  logic                       aclk,
    input  logic                       areset,
    axis_ingress_drop_fifo_if.slave    axis_s,
    axis_ingress_drop_fifo_if.master   axis_m,
    output logic                       packet_committed,
    output logic                       packet_dropped,
    output logic [FIFO_DEPTH_LOG2:0]   occupancy
);
    localparam int unsigned EntryWidth = entry_width(AXIS_BUS_WIDTH, AXIS_DEST_WIDTH);
    localparam int unsigned PtrWidth   = FIFO_DEPTH_LOG2 + 1;
    localparam logic [PtrWidth-1:0] Depth = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};

    state_t                state_q, state_d;
    logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]   commit_ptr_q, commit_ptr_d;
    logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrWidth-1:0]   occupancy_q;
    logic                  committed_q, committed_d;
    logic                  dropped_q, dropped_d;
    logic                  fresh_q, fresh_d;
    logic                  out_valid_q, out_valid_d;
    logic [EntryWidth-1:0] out_entry_q;
    logic [EntryWidth-1:0] wr_entry, ram_rdata;
    logic                  full, wr_en, pop;

    assign axis_s.tready = ~areset;
    assign wr_entry      = {axis_s.tdata, axis_s.tdest, axis_s.tkeep, axis_s.tlast};
    // Uses rd_ptr before this cycle's pop: space freed now is usable next cycle.
    assign full          = (wr_ptr_q - rd_ptr_q) == Depth;

    // Write side: speculative store with rewind on overflow.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        wr_en        = 1'b0;
        committed_d  = 1'b0;
        dropped_d    = 1'b0;
        if (axis_s.tvalid) begin
            case (state_q)
                StIdle, StAccept: begin
                    if (!full) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + PtrWidth'(1);
                        if (axis_s.tlast) begin
                            commit_ptr_d = wr_ptr_q + PtrWidth'(1);
                            committed_d  = 1'b1;
                            state_d      = StIdle;
                        end else begin
                            state_d = StAccept;
                        end
                    end else begin
                        wr_ptr_d = commit_ptr_q;
                        if (axis_s.tlast) begin
                            dropped_d = 1'b1;
                            state_d   = StIdle;
                        end else begin
                            state_d = StDrop;
                        end
                    end
                end
                StDrop: begin
                    if (axis_s.tlast) begin
                        dropped_d = 1'b1;
                        state_d   = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Read side. The RAM is always addressed with the next read pointer, so its output holds
    // mem[rd_ptr]. fresh marks that this entry was committed before the read was issued, i.e.
    // the RAM output is valid data and not a read-before-write of a just-written slot.
    always_comb begin
        pop         = fresh_q & (~out_valid_q | axis_m.tready);
        rd_ptr_d    = rd_ptr_q + PtrWidth'(pop);
        fresh_d     = rd_ptr_d != commit_ptr_q;
        out_valid_d = pop | (out_valid_q & ~axis_m.tready);
    end

    axis_drop_fifo_ram #(
        .WIDTH      (EntryWidth),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_ram (
        .clk     (aclk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q[FIFO_DEPTH_LOG2-1:0]),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr_d[FIFO_DEPTH_LOG2-1:0]),
        .rd_data (ram_rdata)
    );

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            occupancy_q  <= '0;
            committed_q  <= 1'b0;
            dropped_q    <= 1'b0;
            fresh_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            out_entry_q  <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occupancy_q  <= commit_ptr_d - rd_ptr_d;
            committed_q  <= committed_d;
            dropped_q    <= dropped_d;
            fresh_q      <= fresh_d;
            out_valid_q  <= out_valid_d;
            if (pop) begin
                out_entry_q <= ram_rdata;
            end
        end
    end

    assign {axis_m.tdata, axis_m.tdest, axis_m.tkeep, axis_m.tlast} = out_entry_q;
    assign axis_m.tvalid    = out_valid_q;
    assign packet_committed = committed_q;
    assign packet_dropped   = dropped_q;
    assign occupancy        = occupancy_q;
endmodule
